// File: rtl/vec_ld_writeback.sv
// Load write-back stage: queues pending loads, turns each LSU completion into one register-file write.
// Optional build macro VEC_LD_WB_MASK_EN gates element enables with v0_mask.
module vec_ld_writeback #(
    parameter int VLEN     = 512,
    parameter int SEW      = 32,
    parameter int VLMAX    = 16,
    parameter int MAX_VLEN = 4096,
    parameter int NREG     = 32,
    parameter int QDEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [4:0]          issue_vd,
    input  logic [4:0]          issue_vl,
    output logic                issue_ready,
    input  logic [MAX_VLEN-1:0] ld_vd_data,
    input  logic                ld_is_loaded,
    input  logic [VLMAX-1:0]    v0_mask,
    output logic                rf_wr_en,
    output logic [4:0]          rf_wr_addr,
    output logic [VLEN-1:0]     rf_wr_data,
    output logic [VLMAX-1:0]    rf_wr_elem_en,
    output logic [NREG-1:0]     busy_vec,
    output logic                wb_done,
    output logic                err_overrun
);
    localparam int PW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW    = $clog2(QDEPTH + 1);
    localparam int ELEMS = VLEN / SEW;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    logic [4:0]       q_vd [QDEPTH];
    logic [4:0]       q_vl [QDEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [0:0]       state;
    logic             ld_q;
    logic             ld_event;
    logic             push;
    logic             pop;
    logic [4:0]       vl_clamped;
    logic [VLMAX-1:0] vl_en;
    logic [VLMAX-1:0] elem_en_next;
    logic             unused_ld_hi;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ld_event    = ld_is_loaded && !ld_q;
    assign issue_ready = (count < CW'(QDEPTH)) && !busy_vec[issue_vd];
    assign push        = issue_valid && issue_ready;
    assign pop         = (state == S_WRITE);
    assign vl_clamped  = (issue_vl > 5'(VLMAX)) ? 5'(VLMAX) : issue_vl;

    // Only the low VLEN bits of the LSU bus ever reach the register file.
    assign unused_ld_hi = ^ld_vd_data[MAX_VLEN-1:VLEN];

    // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latch).
    always_comb begin
        vl_en = '0;
        for (int i = 0; i < ELEMS; i++) begin
            vl_en[i] = (i < int'(q_vl[head]));
        end
    end

`ifdef VEC_LD_WB_MASK_EN
    assign elem_en_next = vl_en & v0_mask;
`else
    logic unused_v0_mask;
    assign unused_v0_mask = ^v0_mask;
    assign elem_en_next   = vl_en;
`endif

    // NOTE: queue payload is plain storage validated by head/tail/count, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_vd[tail] <= issue_vd;
            q_vl[tail] <= vl_clamped;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            state         <= S_IDLE;
            ld_q          <= 1'b1;
            busy_vec      <= '0;
            rf_wr_en      <= 1'b0;
            wb_done       <= 1'b0;
            err_overrun   <= 1'b0;
            rf_wr_addr    <= '0;
            rf_wr_data    <= '0;
            rf_wr_elem_en <= '0;
        end else begin
            ld_q     <= ld_is_loaded;
            rf_wr_en <= 1'b0;
            wb_done  <= 1'b0;

            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            // Clear before set so a same-register set wins.
            if (pop)  busy_vec[q_vd[head]] <= 1'b0;
            if (push) busy_vec[issue_vd]   <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (ld_event) begin
                        if (count != '0) begin
                            state         <= S_WRITE;
                            rf_wr_en      <= (q_vl[head] != 5'd0);
                            wb_done       <= 1'b1;
                            rf_wr_addr    <= q_vd[head];
                            rf_wr_data    <= ld_vd_data[VLEN-1:0];
                            rf_wr_elem_en <= elem_en_next;
                        end else begin
                            err_overrun <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    if (ld_event) err_overrun <= 1'b1;
                end
            endcase
        end
    end

endmodule
